// File: rtl/wifi_phy_pkg.sv
// Shared WIFI PHY constants: per-constellation block sizes and the interleaver
// permutation step s, used by both the transmit interleaver and the deinterleaver.
package wifi_phy_pkg;

  localparam int COLS = 16;

  // Coded bits per OFDM symbol for a given constellation size.
  function automatic int ncbps_of(input int demapper);
    case (demapper)
      4:       return 96;
      16:      return 192;
      default: return 48;
    endcase
  endfunction

  // Coded bits per subcarrier for a given constellation size.
  function automatic int nbpsc_of(input int demapper);
    case (demapper)
      4:       return 2;
      16:      return 4;
      default: return 1;
    endcase
  endfunction

  // s = max(NBPSC/2, 1)
  function automatic int s_of(input int nbpsc);
    return (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
  endfunction

endpackage

// File: rtl/deint_addr_gen_wifi.sv
// Read-index generator for the deinterleaver: walks k in column-major order
// with nested col/row counters and maps it to the write-order index j.
module deint_addr_gen_wifi
  import wifi_phy_pkg::*;
#(
  parameter  int NCBPS = 48,
  parameter  int S     = 1,
  localparam int AW    = $clog2(NCBPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int ROWS = NCBPS / COLS;
  localparam int RW   = $clog2(ROWS);

  logic [3:0]    col;
  logic [RW-1:0] row;
  logic [AW-1:0] idx;

  assign last = (col == 4'd15) && (row == RW'(ROWS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == 4'd15) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + 4'd1;
      end
    end
  end

  assign idx = AW'(ROWS) * AW'(col) + AW'(row);

  // For 16-QAM the pairs of bits within a subcarrier swap on odd columns.
  generate
    if (S == 2) begin : g_rot
      assign addr = {idx[AW-1:1], idx[0] ^ col[0]};
    end else begin : g_direct
      assign addr = idx;
    end
  endgenerate

endmodule

// File: rtl/deinterleaver_wifi.sv
// 802.11a/g block deinterleaver with ping-pong banks.
// Optional macro WIFI_DEINT_LAST_EN adds a last_out marker on the final bit.
module deinterleaver_wifi
  import wifi_phy_pkg::*;
#(
  parameter int DEMAPPER = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic data_in,
  output logic valid_out,
`ifdef WIFI_DEINT_LAST_EN
  output logic data_out,
  output logic last_out
`else
  output logic data_out
`endif
);

  localparam int NCBPS = ncbps_of(DEMAPPER);
  localparam int NBPSC = nbpsc_of(DEMAPPER);
  localparam int S     = s_of(NBPSC);
  localparam int AW    = $clog2(NCBPS);

  logic [NCBPS-1:0] bank0, bank1;
  logic [AW-1:0]    wr_idx, rd_addr;
  logic             wr_bank, rd_bank, rd_active, rd_last, rd_bit;
  logic             wr_done, rd_done;
  logic [1:0]       full, full_next;

  assign wr_done = valid_in && (wr_idx == AW'(NCBPS - 1));
  assign rd_done = rd_active && rd_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (valid_in) begin
      wr_idx  <= wr_done ? '0 : wr_idx + AW'(1);
      wr_bank <= wr_done ? ~wr_bank : wr_bank;
    end
  end

  // NOTE: bank storage is deliberately not reset; the full flags alone decide
  // whether its contents are ever read.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      if (wr_bank) bank1[wr_idx] <= data_in;
      else         bank0[wr_idx] <= data_in;
    end
  end

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    full_next = full;
    if (rd_done) full_next[rd_bank] = 1'b0;
    if (wr_done) full_next[wr_bank] = 1'b1;
  end

  // A bank completing on the same edge the other finishes reading is picked
  // up immediately through full_next, keeping streaming output gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= '0;
      rd_bank   <= 1'b0;
      rd_active <= 1'b0;
    end else begin
      full <= full_next;
      if (!rd_active) begin
        rd_active <= full[rd_bank];
      end else if (rd_done) begin
        rd_bank   <= ~rd_bank;
        rd_active <= full_next[~rd_bank];
      end
    end
  end

  deint_addr_gen_wifi #(
    .NCBPS (NCBPS),
    .S     (S)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .en    (rd_active),
    .addr  (rd_addr),
    .last  (rd_last)
  );

  assign rd_bit = rd_bank ? bank1[rd_addr] : bank0[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= 1'b0;
    end else begin
      valid_out <= rd_active;
      data_out  <= rd_active & rd_bit;
    end
  end

`ifdef WIFI_DEINT_LAST_EN
  always_ff @(posedge clk) begin
    if (reset) last_out <= 1'b0;
    else       last_out <= rd_done;
  end
`endif

endmodule

// File: tb/tb_deinterleaver_wifi.sv
// Scoreboard bench for deinterleaver_wifi: three instances (BPSK, QPSK, 16-QAM)
// fed by per-instance drivers; expected bits are queued when stimulus is driven.
module tb_deinterleaver_wifi;

  logic clk = 1'b0;
  logic reset;
  logic vin  [3];
  logic din  [3];
  logic vout [3];
  logic dout [3];
`ifdef WIFI_DEINT_LAST_EN
  logic lout [3];
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q [3][$];

  localparam int NB [3] = '{48, 96, 192};
  localparam int SS [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  deinterleaver_wifi #(.DEMAPPER(2)) u_d2 (
    .clk(clk), .reset(reset), .valid_in(vin[0]), .data_in(din[0]),
`ifdef WIFI_DEINT_LAST_EN
    .last_out(lout[0]),
`endif
    .valid_out(vout[0]), .data_out(dout[0]));

  deinterleaver_wifi #(.DEMAPPER(4)) u_d4 (
    .clk(clk), .reset(reset), .valid_in(vin[1]), .data_in(din[1]),
`ifdef WIFI_DEINT_LAST_EN
    .last_out(lout[1]),
`endif
    .valid_out(vout[1]), .data_out(dout[1]));

  deinterleaver_wifi #(.DEMAPPER(16)) u_d16 (
    .clk(clk), .reset(reset), .valid_in(vin[2]), .data_in(din[2]),
`ifdef WIFI_DEINT_LAST_EN
    .last_out(lout[2]),
`endif
    .valid_out(vout[2]), .data_out(dout[2]));

  // Reference permutation: output k takes input bit j.
  task automatic push_model(input int u, input bit [191:0] blk);
    int n, col, row, i, j;
    n = NB[u];
    for (int k = 0; k < n; k++) begin
      col = k % 16;
      row = k / 16;
      i   = (n / 16) * col + row;
      j   = (SS[u] == 2) ? ((i & ~1) | ((i & 1) ^ (col & 1))) : i;
      exp_q[u].push_back(blk[j]);
    end
  endtask

  task automatic push_single(input int u, input int k_one);
    for (int k = 0; k < NB[u]; k++) exp_q[u].push_back(k == k_one);
  endtask

  task automatic drive_bits(input int u, input bit [191:0] blk, input int cnt, input bit gaps);
    for (int j = 0; j < cnt; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        vin[u] = 1'b0;
        din[u] = 1'($urandom);
      end
      @(negedge clk);
      vin[u] = 1'b1;
      din[u] = blk[j];
    end
  endtask

  task automatic drive_idle(input int u);
    @(negedge clk);
    vin[u] = 1'b0;
    din[u] = 1'b0;
  endtask

  function automatic bit [191:0] rand_blk();
    bit [191:0] b;
    for (int w = 0; w < 6; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  // Consumes nb output bursts from instance u against the scoreboard.
  task automatic check_bursts(input int u, input int nb, input bit contig, input string name);
    int  wait_cyc;
    bit  exp_bit, gap_seen;
    for (int b = 0; b < nb; b++) begin
      wait_cyc = 0;
      gap_seen = 1'b0;
      while (vout[u] !== 1'b1 && wait_cyc < 2000) begin
        vectors++;
        if (dout[u] !== 1'b0) begin
          miscompares++;
          $display("FAIL %s idle_data: data_out=%b expected 0", name, dout[u]);
        end
        if (contig && b > 0 && !gap_seen) begin
          gap_seen = 1'b1;
          miscompares++;
          $display("FAIL %s gap_before_burst%0d: valid_out=0 expected 1", name, b);
        end
        @(negedge clk);
        wait_cyc++;
      end
      if (wait_cyc >= 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL %s timeout burst%0d: no valid_out expected a burst", name, b);
        return;
      end
      for (int k = 0; k < NB[u]; k++) begin
        exp_bit = (exp_q[u].size() > 0) ? exp_q[u].pop_front() : 1'b0;
        vectors++;
        if (vout[u] !== 1'b1 || dout[u] !== exp_bit) begin
          miscompares++;
          $display("FAIL %s burst%0d k=%0d: valid=%b data=%b expected valid=1 data=%b",
                   name, b, k, vout[u], dout[u], exp_bit);
        end
`ifdef WIFI_DEINT_LAST_EN
        vectors++;
        if (lout[u] !== (k == NB[u] - 1)) begin
          miscompares++;
          $display("FAIL %s last_out k=%0d: got %b expected %b", name, k, lout[u], k == NB[u] - 1);
        end
`endif
        @(negedge clk);
      end
    end
    for (int c = 0; c < 64; c++) begin
      vectors++;
      if (vout[u] !== 1'b0 || dout[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s extra_output: valid=%b data=%b expected 0/0", name, vout[u], dout[u]);
      end
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      vin[u] = 1'b0;
      din[u] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if (vout[u] !== 1'b0 || dout[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset u%0d: valid=%b data=%b expected 0/0", u, vout[u], dout[u]);
      end
`ifdef WIFI_DEINT_LAST_EN
      vectors++;
      if (lout[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_last u%0d: got %b expected 0", u, lout[u]);
      end
`endif
    end
  endtask

  task automatic test_single_bpsk();
    bit [191:0] blk = '0;
    blk[1] = 1'b1;
    push_single(0, 16);
    drive_bits(0, blk, 48, 1'b0);
    drive_idle(0);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (vout[0] !== (c == 2)) begin
        miscompares++;
        $display("FAIL bpsk_latency cycle%0d: valid_out=%b expected %b", c + 1, vout[0], c == 2);
      end
      if (c < 2) @(negedge clk);
    end
    check_bursts(0, 1, 1'b0, "bpsk_single");
  endtask

  task automatic test_single_qpsk();
    bit [191:0] blk = '0;
    blk[7] = 1'b1;
    push_single(1, 17);
    drive_bits(1, blk, 96, 1'b0);
    drive_idle(1);
    check_bursts(1, 1, 1'b0, "qpsk_single");
  endtask

  task automatic test_qam16();
    bit [191:0] b0 = '0;
    bit [191:0] b1 = '0;
    b0[13] = 1'b1;
    b1[12] = 1'b1;
    push_single(2, 1);
    push_single(2, 17);
    fork
      begin
        drive_bits(2, b0, 192, 1'b0);
        drive_bits(2, b1, 192, 1'b0);
        drive_idle(2);
      end
      check_bursts(2, 2, 1'b1, "qam16_pair");
    join
  endtask

  task automatic test_back_to_back();
    bit [191:0] b0 = rand_blk();
    bit [191:0] b1 = rand_blk();
    push_model(0, b0);
    push_model(0, b1);
    fork
      begin
        drive_bits(0, b0, 48, 1'b0);
        drive_bits(0, b1, 48, 1'b0);
        drive_idle(0);
      end
      check_bursts(0, 2, 1'b1, "bpsk_back_to_back");
    join
  endtask

  task automatic test_gaps();
    bit [191:0] blks [3];
    for (int b = 0; b < 3; b++) begin
      blks[b] = rand_blk();
      push_model(1, blks[b]);
    end
    fork
      begin
        for (int b = 0; b < 3; b++) drive_bits(1, blks[b], 96, 1'b1);
        drive_idle(1);
      end
      check_bursts(1, 3, 1'b0, "qpsk_gaps");
    join
  endtask

  task automatic test_reset_abort();
    bit [191:0] junk  = rand_blk();
    bit [191:0] fresh = rand_blk();
    drive_bits(0, junk, 30, 1'b0);
    apply_reset();
    push_model(0, fresh);
    drive_bits(0, fresh, 48, 1'b0);
    drive_idle(0);
    check_bursts(0, 1, 1'b0, "bpsk_reset_abort");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      vin[u] = 1'b0;
      din[u] = 1'b0;
    end
    test_reset();
    test_single_bpsk();
    test_single_qpsk();
    test_qam16();
    test_back_to_back();
    test_gaps();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
